// File: rtl/gamma_lut_sched_if.sv
// gamma_lut_sched_if: bundles the pixel-in, pixel-out, host-config and LUT-RAM
// signals of gamma_lut_sched.
//   master : environment side (pixel source/sink, host, LUT RAM)
//   slave  : the scheduler itself
interface gamma_lut_sched_if;
  logic [15:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic        bypass;
  logic [15:0] pix_out;
  logic        out_valid;
  logic        out_ready;
  logic        cfg_wr_req;
  logic [5:0]  cfg_addr;
  logic [5:0]  cfg_data;
  logic        cfg_wr_ack;
  logic [5:0]  lut_addr;
  logic        lut_rd_en;
  logic        lut_we;
  logic [5:0]  lut_wdata;
  logic [5:0]  lut_rdata;
  logic        busy;

  modport master (
    output pix_in, pix_valid, bypass, out_ready, cfg_wr_req, cfg_addr, cfg_data, lut_rdata,
    input  pix_ready, pix_out, out_valid, cfg_wr_ack, lut_addr, lut_rd_en, lut_we, lut_wdata, busy
  );

  modport slave (
    input  pix_in, pix_valid, bypass, out_ready, cfg_wr_req, cfg_addr, cfg_data, lut_rdata,
    output pix_ready, pix_out, out_valid, cfg_wr_ack, lut_addr, lut_rd_en, lut_we, lut_wdata, busy
  );
endinterface

// File: rtl/gamma_lut_sched.sv
// gamma_lut_sched: shares one 64x6 single-port gamma LUT (1-cycle read latency)
// between the RGB565 pixel path and host table writes. Each pixel gets three
// sequential lookups (R, G, B); host writes are only granted in IDLE, so a
// pixel always sees one consistent table. Writes and pixels alternate when
// both sides request continuously.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus.slave  : pixel in (pix_in/pix_valid/pix_ready/bypass),
//                pixel out (pix_out/out_valid/out_ready),
//                host write (cfg_wr_req/cfg_addr/cfg_data/cfg_wr_ack),
//                LUT RAM (lut_addr/lut_rd_en/lut_we/lut_wdata/lut_rdata), busy
//
// state | meaning
// IDLE  | arbitrate host write vs next pixel
// LK_R  | R lookup issued
// LK_G  | G lookup issued, R result returning
// LK_B  | B lookup issued, G result returning
// CAP_B | B result returning, assemble output
// OUT   | output valid, waiting for out_ready
// WR    | LUT write + ack pulse
module gamma_lut_sched (
  input logic clk,
  input logic rst_n,
  gamma_lut_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LK_R, LK_G, LK_B, CAP_B, OUT, WR} state_t;

  state_t      state, state_d;
  logic        wr_prio, wr_prio_d;
  logic [10:0] gb_q, gb_q_d;
  logic [5:0]  r_q, r_q_d, g_q, g_q_d;
  logic [15:0] pix_out_q, pix_out_d;
  logic        out_valid_q, out_valid_d;
  logic        ack_q, ack_d;
  logic        we_q, we_d;
  logic        rd_en_q, rd_en_d;
  logic [5:0]  addr_q, addr_d;
  logic [5:0]  wdata_q, wdata_d;
  logic        busy_q;
  logic        pix_ready_c, wr_grant, pix_acc;

  // Ready does not look at pix_valid; a waiting writer without priority only
  // wins when no pixel is offered, which wr_grant handles.
  assign pix_ready_c = (state == IDLE) && !(bus.cfg_wr_req && wr_prio);
  assign wr_grant    = (state == IDLE) && bus.cfg_wr_req && (wr_prio || !bus.pix_valid);
  assign pix_acc     = bus.pix_valid && pix_ready_c;

  // All outputs except pix_ready are registered, so this block computes the
  // values they take in the next cycle.
  always_comb begin
    state_d     = state;
    wr_prio_d   = wr_prio;
    gb_q_d      = gb_q;
    r_q_d       = r_q;
    g_q_d       = g_q;
    pix_out_d   = pix_out_q;
    out_valid_d = out_valid_q;
    ack_d       = 1'b0;
    we_d        = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state)
      IDLE: begin
        if (wr_grant) begin
          state_d = WR;
          we_d    = 1'b1;
          ack_d   = 1'b1;
          addr_d  = bus.cfg_addr;
          wdata_d = bus.cfg_data;
        end else if (pix_acc) begin
          gb_q_d = bus.pix_in[10:0];
          if (bus.bypass) begin
            state_d     = OUT;
            pix_out_d   = bus.pix_in;
            out_valid_d = 1'b1;
          end else begin
            state_d = LK_R;
            rd_en_d = 1'b1;
            addr_d  = {bus.pix_in[15:11], 1'b0};
          end
        end
      end
      LK_R: begin
        state_d = LK_G;
        rd_en_d = 1'b1;
        addr_d  = gb_q[10:5];
      end
      LK_G: begin
        state_d = LK_B;
        rd_en_d = 1'b1;
        addr_d  = {gb_q[4:0], 1'b0};
        r_q_d   = bus.lut_rdata;
      end
      LK_B: begin
        state_d = CAP_B;
        g_q_d   = bus.lut_rdata;
      end
      CAP_B: begin
        state_d     = OUT;
        pix_out_d   = {r_q[5:1], g_q, bus.lut_rdata[5:1]};
        out_valid_d = 1'b1;
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          wr_prio_d   = 1'b1;
        end
      end
      WR: begin
        state_d   = IDLE;
        wr_prio_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_prio     <= 1'b1;
      gb_q        <= '0;
      r_q         <= '0;
      g_q         <= '0;
      pix_out_q   <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      we_q        <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_d;
      wr_prio     <= wr_prio_d;
      gb_q        <= gb_q_d;
      r_q         <= r_q_d;
      g_q         <= g_q_d;
      pix_out_q   <= pix_out_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
      we_q        <= we_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.pix_ready  = pix_ready_c;
  assign bus.pix_out    = pix_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.cfg_wr_ack = ack_q;
  assign bus.lut_addr   = addr_q;
  assign bus.lut_rd_en  = rd_en_q;
  assign bus.lut_we     = we_q;
  assign bus.lut_wdata  = wdata_q;
  assign bus.busy       = busy_q;
endmodule
